// File: rtl/multicycle_mem_responder.sv
// Unified fetch/load/store memory responder with programmable wait states.
// Optional feature: define MISALIGN_TRAP_EN to fault accesses with req_addr[1:0] != 0.
module multicycle_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CNT_LD  = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          in_range;
  logic          misaligned;
  logic          fault;

  // With zero wait states the access is served straight from the request
  // inputs, so the access operands are muxed between live and latched values.
  always_comb begin
    accept     = (state_q == S_IDLE) && req_valid;
    enter_resp = (accept && NO_WAIT) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
    acc_we     = (state_q == S_IDLE) ? req_we    : we_q;
    acc_addr   = (state_q == S_IDLE) ? req_addr  : addr_q;
    acc_wdata  = (state_q == S_IDLE) ? req_wdata : wdata_q;
    acc_idx    = acc_addr[AW+1:2];
    in_range   = acc_addr[31:2] < 30'(DEPTH_WORDS);
    misaligned = TRAP_MISALIGN && (acc_addr[1:0] != 2'b00);
    fault      = !in_range || misaligned;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (NO_WAIT) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      valid_d = 1'b1;
      rdata_d = fault ? '0 : mem[acc_idx];
      err_d   = fault;
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage is never reset; a reset before RESP simply suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && acc_we && !fault) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Bench for multicycle_mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
// checked against an array model of the memory contents.
module tb_multicycle_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_rv, a_err;
  logic [31:0] a_rdata;
  logic        b_valid = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_rv, b_err;
  logic [31:0] b_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_a [64];
  logic [31:0] mdl_b [64];

  always #5 clk = ~clk;

  multicycle_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err)
  );

  multicycle_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err)
  );

  // Reference: faults on word >= 64 (and misalignment when trapping), faulted
  // accesses read 0 and never write; stores return the old word.
  function automatic void model(input bit use_b, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd,
                                output logic e);
    int unsigned w;
    bit mis;
    w = addr >> 2;
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (addr[1:0] != 2'b00);
`endif
    e = (w >= 64) || mis;
    rd = '0;
    if (!e) begin
      rd = use_b ? mdl_b[w] : mdl_a[w];
      if (we) begin
        if (use_b) mdl_b[w] = wdata;
        else       mdl_a[w] = wdata;
      end
    end
  endfunction

  // Issue one request to the WAIT_CYCLES=2 instance; lat is the number of
  // cycles after the accept edge until resp_valid (0 = never seen).
  task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output int ready_lo);
    @(negedge clk);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_we = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
    lat = 0; ready_lo = 0; rdata = 'x; err = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!a_ready) ready_lo++;
      if (a_rv) begin
        lat = k; rdata = a_rdata; err = a_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h4; a_wdata = $urandom;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h4; b_wdata = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_rv !== 1'b0 || b_rv !== 1'b0) begin
      errors++; $display("FAIL reset_rv_during: got a=%b b=%b expected 0", a_rv, b_rv);
    end
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b expected 1", a_ready, b_ready);
    end
    checks++;
    if ({a_rv, a_err, a_rdata} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: got rv=%b err=%b rdata=%h expected 0", a_rv, a_err, a_rdata);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (a_rv !== 1'b0 || b_rv !== 1'b0) begin
        errors++; $display("FAIL reset_no_accept: got a=%b b=%b expected 0", a_rv, b_rv);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] rd, v; logic e; int lat, rl;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      run_a(1'b1, 32'(i * 4), v, rd, e, lat, rl);
      mdl_a[i] = v;
      checks++;
      if (lat !== 3 || e !== 1'b0) begin
        errors++; $display("FAIL fill_%0d: got lat=%0d err=%b expected lat=3 err=0", i, lat, e);
      end
    end
  endtask

  task automatic test_load_basic();
    logic [31:0] rd, xr; logic e, xe; int lat, rl;
    model(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, xr, xe);
    run_a(1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, rl);
    model(1'b0, 1'b0, 32'h10, 32'h0, xr, xe);
    run_a(1'b0, 32'h10, $urandom, rd, e, lat, rl);
    checks++;
    if (rl !== 3) begin errors++; $display("FAIL load_ready_low: got %0d expected 3", rl); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL load_latency: got %0d expected 3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++; $display("FAIL load_data: got %h err=%b expected deadbeef err=0", rd, e);
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_rv !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_after: got ready=%b rv=%b rdata=%h expected 1 0 deadbeef", a_ready, a_rv, a_rdata);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, xr, old; logic e, xe; int lat, rl;
    old = mdl_a[8];
    model(1'b0, 1'b1, 32'h20, 32'h12345678, xr, xe);
    run_a(1'b1, 32'h20, 32'h12345678, rd, e, lat, rl);
    checks++;
    if (rd !== old || e !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL store_old: got %h err=%b lat=%0d expected %h 0 3", rd, e, lat, old);
    end
    run_a(1'b0, 32'h20, $urandom, rd, e, lat, rl);
    checks++;
    if (rd !== 32'h12345678 || e !== 1'b0) begin
      errors++; $display("FAIL store_readback: got %h err=%b expected 12345678 0", rd, e);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic e; int lat, rl, bad;
    run_a(1'b0, 32'h100, $urandom, rd, e, lat, rl);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1 || lat !== 3) begin
      errors++; $display("FAIL oor_load: got %h err=%b lat=%0d expected 0 1 3", rd, e, lat);
    end
    run_a(1'b1, 32'h100, 32'hCAFEF00D, rd, e, lat, rl);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL oor_store: got %h err=%b expected 0 1", rd, e);
    end
    run_a(1'b1, 32'hFFFF_FFFC, 32'h0BADCAFE, rd, e, lat, rl);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL oor_store_high: got %h err=%b expected 0 1", rd, e);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      run_a(1'b0, 32'(i * 4), 32'h0, rd, e, lat, rl);
      if (rd !== mdl_a[i] || e !== 1'b0) begin
        bad++; $display("FAIL oor_word_%0d: got %h expected %h", i, rd, mdl_a[i]);
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL oor_unchanged: got %0d bad words expected 0", bad); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd, xr; logic e, xe; int lat, rl;
    model(1'b0, 1'b0, 32'h6, 32'h0, xr, xe);
    run_a(1'b0, 32'h6, $urandom, rd, e, lat, rl);
    checks++;
    if (rd !== xr || e !== xe || lat !== 3) begin
      errors++; $display("FAIL misalign_load: got %h err=%b lat=%0d expected %h %b 3", rd, e, lat, xr, xe);
    end
    model(1'b0, 1'b1, 32'h5, 32'h5A5A0F0F, xr, xe);
    run_a(1'b1, 32'h5, 32'h5A5A0F0F, rd, e, lat, rl);
    model(1'b0, 1'b0, 32'h4, 32'h0, xr, xe);
    run_a(1'b0, 32'h4, $urandom, rd, e, lat, rl);
    checks++;
    if (rd !== xr || e !== xe) begin
      errors++; $display("FAIL misalign_store: got %h err=%b expected %h %b", rd, e, xr, xe);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic e; int lat, rl, seen;
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h8; a_wdata = 32'hAAAA5555;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_wait_busy: got ready=%b expected 0", a_ready); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (a_ready !== 1'b1 || a_rv !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
      errors++; $display("FAIL rst_wait_after: got ready=%b rv=%b rdata=%h err=%b expected 1 0 0 0", a_ready, a_rv, a_rdata, a_err);
    end
    seen = 0;
    repeat (5) begin @(negedge clk); if (a_rv) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_wait_no_resp: got %0d pulses expected 0", seen); end
    run_a(1'b0, 32'h8, $urandom, rd, e, lat, rl);
    checks++;
    if (rd !== mdl_a[2] || e !== 1'b0) begin
      errors++; $display("FAIL rst_wait_word2: got %h expected %h", rd, mdl_a[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, xr, addr, wd; logic e, xe, we; int lat, rl;
    for (int n = 0; n < 40; n++) begin
      addr = 32'($urandom_range(0, 71) * 4);
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      we = 1'($urandom);
      wd = $urandom;
      model(1'b0, we, addr, wd, xr, xe);
      run_a(we, addr, wd, rd, e, lat, rl);
      checks++;
      if (rd !== xr || e !== xe || lat !== 3 || rl !== 3) begin
        errors++;
        $display("FAIL random_%0d addr=%h we=%b: got %h err=%b lat=%0d rlo=%0d expected %h %b 3 3",
                 n, addr, we, rd, e, lat, rl, xr, xe);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xr, v; logic xe;
    for (int i = 0; i < 2; i++) begin
      v = $urandom;
      @(negedge clk);
      b_valid = 1'b1; b_we = 1'b1; b_addr = 32'(i * 4); b_wdata = v;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (b_rv !== 1'b1 || b_err !== 1'b0) begin
        errors++; $display("FAIL b2b_fill_%0d: got rv=%b err=%b expected 1 0", i, b_rv, b_err);
      end
      mdl_b[i] = v;
    end
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", b_ready); end
    b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h0;
    @(posedge clk);
    #1;
    b_addr = 32'h4;
    @(negedge clk);
    model(1'b1, 1'b0, 32'h0, 32'h0, xr, xe);
    checks++;
    if (b_rv !== 1'b1 || b_ready !== 1'b0 || b_rdata !== xr || b_err !== xe) begin
      errors++; $display("FAIL b2b_resp1: got rv=%b ready=%b rdata=%h expected 1 0 %h", b_rv, b_ready, b_rdata, xr);
    end
    @(negedge clk);
    checks++;
    if (b_rv !== 1'b0 || b_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: got rv=%b ready=%b expected 0 1", b_rv, b_ready);
    end
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    @(negedge clk);
    model(1'b1, 1'b0, 32'h4, 32'h0, xr, xe);
    checks++;
    if (b_rv !== 1'b1 || b_ready !== 1'b0 || b_rdata !== xr || b_err !== xe) begin
      errors++; $display("FAIL b2b_resp2: got rv=%b ready=%b rdata=%h expected 1 0 %h", b_rv, b_ready, b_rdata, xr);
    end
    @(negedge clk);
    checks++;
    if (b_rv !== 1'b0 || b_ready !== 1'b1 || b_rdata !== xr) begin
      errors++; $display("FAIL b2b_idle: got rv=%b ready=%b rdata=%h expected 0 1 %h", b_rv, b_ready, b_rdata, xr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_basic();
    test_store_load();
    test_out_of_range();
    test_misalign();
    test_reset_in_wait();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
